// File: rtl/vga_pkg.sv
// Shared VGA definitions: default geometry, compositor modes and colour constants.
package vga_pkg;

  localparam int unsigned CW_DEF       = 4;
  localparam int unsigned XW_DEF       = 11;
  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned V_ACTIVE_DEF = 600;

  // Widest channel the colour helpers support; callers cast down to 3*CW bits.
  localparam int unsigned MAX_CW = 16;

  typedef enum logic [1:0] {
    MODE_BORDER    = 2'b00,
    MODE_PATTERN   = 2'b01,
    MODE_LAYER     = 2'b10,
    MODE_LAYER_PAT = 2'b11
  } mode_e;

  function automatic logic [3*MAX_CW-1:0] white(input int unsigned cw);
    white = '0;
    for (int i = 0; i < 3 * MAX_CW; i++) begin
      if (i < 3 * cw) white[i] = 1'b1;
    end
  endfunction

  function automatic logic [3*MAX_CW-1:0] black(input int unsigned cw);
    black = '0;
    for (int i = 0; i < 3 * MAX_CW; i++) begin
      if (i < 3 * cw) black[i] = 1'b0;
    end
  endfunction

endpackage

// File: rtl/vga_layer_mux.sv
// Priority overlay select: the lowest-index layer flagged valid supplies the colour.
module vga_layer_mux
  import vga_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned CW         = CW_DEF
) (
  input  logic [NUM_LAYERS*3*CW-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]      layer_valid,
  output logic [3*CW-1:0]            rgb,
  output logic                       hit
);

  always_comb begin
    rgb = '0;
    hit = 1'b0;
    // Walk from the lowest priority upward so layer 0 is written last.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_valid[i]) begin
        rgb = layer_rgb[i*3*CW +: 3*CW];
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Per-pixel colour generator: synchronised mode select, animated pattern, overlay layers,
// two-stage registered pipeline from timing-generator inputs to the DAC pins.
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned CW         = CW_DEF,
  parameter int unsigned XW         = XW_DEF,
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned BORDER     = 100
) (
  input  logic                       CLK_100MHz,
  input  logic                       RESET_N,
  input  logic [XW-1:0]              CurrentX,
  input  logic [XW-1:0]              CurrentY,
  input  logic                       VBlank,
  input  logic                       HBlank,
  input  logic [4:0]                 SWITCH,
  input  logic [NUM_LAYERS*3*CW-1:0] LAYER_RGB,
  input  logic [NUM_LAYERS-1:0]      LAYER_VALID,
  output logic [CW-1:0]              RED,
  output logic [CW-1:0]              GREEN,
  output logic [CW-1:0]              BLUE,
  output logic                       PIX_VALID,
  output logic [7:0]                 FRAME_CNT
);

  localparam logic [3*CW-1:0] WHITE   = (3*CW)'(white(CW));
  localparam logic [3*CW-1:0] BLACK   = (3*CW)'(black(CW));
  localparam logic [CW-1:0]   GREY_CH = CW'((1 << (CW - 1)) - 1);
  localparam logic [XW-1:0]   X_LO    = XW'(BORDER);
  localparam logic [XW-1:0]   X_HI    = XW'(H_ACTIVE - BORDER);
  localparam logic [XW-1:0]   Y_LO    = XW'(BORDER);
  localparam logic [XW-1:0]   Y_HI    = XW'(V_ACTIVE - BORDER);
  // Only the low 3*CW+4 product bits feed the pattern, so the multiply is kept that narrow.
  localparam int unsigned     PL      = 3 * CW + 4;

  logic [4:0]                 sw_m, sw_s;
  mode_e                      mode_q;
  logic [2:0]                 csel_q;
  logic                       vb_d;
  logic [7:0]                 frame_q;
  logic                       ready_q;
  logic [XW-1:0]              x_s1, y_s1;
  logic                       act_s1;
  logic [NUM_LAYERS*3*CW-1:0] lrgb_s1;
  logic [NUM_LAYERS-1:0]      lval_s1;
  logic [3*CW-1:0]            pat_s1;
  logic [3*CW-1:0]            rgb_q;
  logic                       valid_q;

  logic                       blank;
  logic [PL-1:0]              px, ps, prod;
  logic [3*CW-1:0]            fill, layer_rgb, col_d;
  logic                       layer_hit, border;

  assign blank = VBlank | HBlank;
  assign px    = PL'(CurrentX);
  assign ps    = PL'(CurrentY) + PL'(frame_q);
  assign prod  = px * ps;

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_m    <= '0;
      sw_s    <= '0;
      mode_q  <= MODE_BORDER;
      csel_q  <= '0;
      vb_d    <= 1'b0;
      frame_q <= '0;
      ready_q <= 1'b0;
    end else begin
      sw_m    <= SWITCH;
      sw_s    <= sw_m;
      vb_d    <= VBlank;
      ready_q <= 1'b1;
      if (blank) begin
        mode_q <= mode_e'(sw_s[4:3]);
        csel_q <= sw_s[2:0];
      end
      if (VBlank && !vb_d) frame_q <= frame_q + 8'd1;
    end
  end

  // Stage 1. ready_q masks the first post-reset sample so PIX_VALID stays low for two clocks.
  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      x_s1    <= '0;
      y_s1    <= '0;
      act_s1  <= 1'b0;
      lrgb_s1 <= '0;
      lval_s1 <= '0;
      pat_s1  <= '0;
    end else begin
      x_s1    <= CurrentX;
      y_s1    <= CurrentY;
      act_s1  <= ~blank & ready_q;
      lrgb_s1 <= LAYER_RGB;
      lval_s1 <= LAYER_VALID;
      pat_s1  <= prod[PL-1:4];
    end
  end

  vga_layer_mux #(
    .NUM_LAYERS(NUM_LAYERS),
    .CW        (CW)
  ) u_layer_mux (
    .layer_rgb  (lrgb_s1),
    .layer_valid(lval_s1),
    .rgb        (layer_rgb),
    .hit        (layer_hit)
  );

  always_comb begin
    fill = {csel_q[2] ? {CW{1'b1}} : {CW{1'b0}},
            csel_q[1] ? {CW{1'b1}} : {CW{1'b0}},
            csel_q[0] ? {CW{1'b1}} : {CW{1'b0}}};
    if (csel_q == 3'b111) fill = {3{GREY_CH}};
    border = (x_s1 < X_LO) || (x_s1 >= X_HI) || (y_s1 < Y_LO) || (y_s1 >= Y_HI);
    unique case (mode_q)
      MODE_BORDER:    col_d = border ? WHITE : fill;
      MODE_PATTERN:   col_d = pat_s1;
      MODE_LAYER:     col_d = layer_hit ? layer_rgb : fill;
      MODE_LAYER_PAT: col_d = layer_hit ? layer_rgb : pat_s1;
      default:        col_d = BLACK;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      rgb_q   <= act_s1 ? col_d : BLACK;
      valid_q <= act_s1;
    end
  end

  assign RED       = rgb_q[3*CW-1:2*CW];
  assign GREEN     = rgb_q[2*CW-1:CW];
  assign BLUE      = rgb_q[CW-1:0];
  assign PIX_VALID = valid_q;
  assign FRAME_CNT = frame_q;

endmodule
